alu_op_issue: RTL

//  Producer side of the ALU operation interface: decodes ALUOp/funct3/funct7[5] into the 4-bit ALU

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issue_skid.sv | 81 ++++++++
 rtl/alu_op_issue.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Op-code constants and ALUOp encoding shared between the issue
//             stage (alu_op_issue) and the EX-stage ALU.
//  Contents : OP_AND / OP_OR / OP_ADD / OP_SUB / OP_NONE  - 4-bit ALU op codes
//             alu_op_e                                    - 2-bit ALUOp class
//             alu_dec_t                                   - decode result
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    // The ALU drives a zero result for this code.
    localparam logic [3:0] OP_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,  // load/store address add
        ALUOP_BR  = 2'b01,  // branch compare subtract
        ALUOP_R   = 2'b10,  // R-type, refined by funct7[5]/funct3
        ALUOP_RSV = 2'b11   // reserved, always illegal
    } alu_op_e;

    typedef struct packed {
        logic       illegal;
        logic [3:0] operation;
    } alu_dec_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_skid.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_skid
//  Purpose  : Generic 2-entry (main + skid) valid/ready buffer. The output
//             payload always comes straight from the main register, so there
//             is no combinational path from input to output. in_ready is a
//             direct function of the skid flop (ready iff skid empty).
//  Ports    : clk        in   clock
//             reset      in   async active-high reset
//             flush      in   sync, empties both entries
//             in_valid   in   upstream valid
//             in_ready   out  skid entry empty
//             in_data    in   DATA_W payload
//             out_valid  out  main entry occupied
//             out_ready  in   downstream accepts
//             out_data   out  DATA_W payload from main entry
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_skid #(
    parameter int DATA_W = 133
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_in_fire;

    // Input can only land when the skid slot is free; when full the only
    // legal move is skid -> main, so no input is taken that cycle.
    assign w_in_fire = in_valid & ~r_skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Payload registers keep their last value; valids qualify them.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (out_ready) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (r_main_valid) begin
            if (out_ready) begin
                // Main drains and refills in the same cycle for full rate.
                if (w_in_fire) begin
                    r_main_data <= in_data;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_in_fire) begin
            r_main_data  <= in_data;
            r_main_valid <= 1'b1;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule : alu_issue_skid
`default_nettype wire

// File: rtl/alu_op_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_issue
//  Purpose  : Producer side of the ALU operation interface. Decodes
//             ALUOp/funct3/funct7[5] into the 4-bit ALU op code and issues it,
//             with both operands, through a 2-entry skid buffer to the EX ALU.
//             Supports a synchronous flush for branch mispredicts.
//  Ports    : clk        in   clock
//             reset      in   async active-high reset
//             flush      in   drop all buffered ops and the op presented now
//             in_valid   in   upstream op valid
//             in_ready   out  block can accept an op this cycle
//             alu_op     in   [1:0] ALUOp class (see alu_op_e)
//             funct3     in   [2:0] instruction funct3
//             funct7_5   in   instruction bit 30
//             rs1_data   in   [WIDTH-1:0] operand 1
//             rs2_data   in   [WIDTH-1:0] operand 2
//             out_valid  out  operation/data1/data2/illegal valid
//             out_ready  in   ALU accepts this cycle
//             operation  out  [3:0] ALU op code
//             data1      out  [WIDTH-1:0] operand 1 to ALU
//             data2      out  [WIDTH-1:0] operand 2 to ALU
//             illegal    out  decode failed, operation = OP_NONE
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic             illegal
);

    // Payload layout: {illegal, operation[3:0], data1, data2}
    localparam int c_PAYLOAD_W = 2 * WIDTH + 5;

    function automatic alu_dec_t decode(
        input logic [1:0] op_class,
        input logic       f7_5,
        input logic [2:0] f3
    );
        alu_dec_t d;
        d.illegal   = 1'b0;
        d.operation = OP_NONE;
        case (alu_op_e'(op_class))
            ALUOP_MEM: d.operation = OP_ADD;
            ALUOP_BR:  d.operation = OP_SUB;
            ALUOP_R: begin
                case ({f7_5, f3})
                    4'b0_000: d.operation = OP_ADD;
                    4'b1_000: d.operation = OP_SUB;
                    4'b0_111: d.operation = OP_AND;
                    4'b0_110: d.operation = OP_OR;
                    default:  d.illegal   = 1'b1;
                endcase
            end
            ALUOP_RSV: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    alu_dec_t                 w_dec;
    logic [c_PAYLOAD_W-1:0]   w_in_payload;
    logic [c_PAYLOAD_W-1:0]   w_out_payload;
    logic                     w_in_valid;

    assign w_dec        = decode(alu_op, funct7_5, funct3);
    assign w_in_payload = {w_dec.illegal, w_dec.operation, rs1_data, rs2_data};

    // An op presented together with flush belongs to the squashed path.
    assign w_in_valid   = in_valid & ~flush;

    alu_issue_skid #(
        .DATA_W (c_PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (w_in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign illegal   = w_out_payload[c_PAYLOAD_W-1];
    assign operation = w_out_payload[c_PAYLOAD_W-2 -: 4];
    assign data1     = w_out_payload[2*WIDTH-1 -: WIDTH];
    assign data2     = w_out_payload[WIDTH-1:0];

endmodule : alu_op_issue
`default_nettype wire
